writeback_stage: RTL and testbench
==================================

# writeback_stage

Parametrised MEM/WB pipeline stage for the RV32I core. It replaces the bare writeback multiplexer with a registered stage that does four things: selects among five result sources, formats load data (byte/half/word, signed/unsigned), flags misaligned loads, and holds the pipeline while a data-memory response is outstanding. It sits between the data-memory port and the register-file write port and drives `resultW`, `rdW` and `regwriteW` to the register file and hazard unit.

## Interface
- `W`, 32, datapath width; must be 32 in this generation (byte-lane logic is fixed at 4 lanes).
- `RA_W`, 5, register-address width.
- `CNT_W`, 64, retirement-counter width (used only with `WB_INSTRET_EN`).

Ports:
- `clk` in 1: the single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `validM` in 1: the MEM-stage slot holds a real instruction.
- `resultsrcM` in 3: result source select.
  - 000 ALU, 001 load, 010 PC+4, 011 immediate, 100 CSR read.
  - 101–111 behave as ALU.
- `funct3M` in 3: load size and sign.
- `aluresultM` in W: ALU result; for loads, the byte address.
- `pcplus4M` in W: PC+4 of the instruction.
- `immextM` in W: extended immediate.
- `csrdataM` in W: CSR read data.
- `rdM` in RA_W: destination register.
- `regwriteM` in 1: instruction writes `rd`.
- `memrdata` in W: raw aligned word from data memory.
- `memrvalid` in 1: `memrdata` is valid this cycle.
- `stallM` out 1: hold IF/ID/EX/MEM; combinational.
- `resultW` out W: registered writeback value.
- `rdW` out RA_W: registered destination register.
- `regwriteW` out 1: registered write enable, already qualified.
- `validW` out 1: registered valid.
- `misalignW` out 1: registered misaligned-load flag.
- `instretW` out CNT_W: retired-instruction count.

## Operation
- FSM states: RUN and WAIT.
- A pending load is `validM & resultsrcM==001 & !memrvalid`.
- In RUN, a pending load raises `stallM` and moves the FSM to WAIT.
- In WAIT, `stallM` stays high until `memrvalid` is seen; on that cycle `stallM` drops and the FSM returns to RUN.
- While `stallM` is high:
  - upstream holds all M inputs stable;
  - the WB register loads a bubble (`validW=0`, `regwriteW=0`); `resultW` and `rdW` hold their previous values.
- When `stallM` is low, the WB register captures:
  - `validW ← validM`;
  - `rdW ← rdM`;
  - `resultW ←` the selected source, with load data formatted;
  - `misalignW ← validM & isload & misaligned`;
  - `regwriteW ← validM & regwriteM & (rdM≠0) & !misaligned`.
- Load formatting uses `off = aluresultM[1:0]`:
  - LB (000) / LBU (100): byte `off`, sign- or zero-extended.
  - LH (001) / LHU (101): halfword at `off[1]`, sign- or zero-extended.
  - LW (010) and any other `funct3`: the full word.
- A load is misaligned when it is a halfword with `off[0]=1`, or a word with `off≠0`.
  - A misaligned load still retires (`validW=1`) with `regwriteW=0` and `misalignW=1`.
  - `resultW` for it is undefined; the bench must not check it.
- A non-load instruction never stalls, whatever `memrvalid` is.
- `memrvalid` outside a load is ignored.

## Timing
- Latency from M inputs to W outputs is 1 cycle when there is no stall.
- A load with `memrvalid` high in its first MEM cycle has zero stall cycles.
- A load whose response arrives N cycles late stalls for exactly N cycles and retires on the edge after `memrvalid`.
- `stallM` is forced to 0 while `rst` is high.
- Reset values:
  - `resultW=0`, `rdW=0`, `regwriteW=0`, `validW=0`, `misalignW=0`, `instretW=0`;
  - FSM in RUN.
- Reset while in WAIT abandons the load; the next cycle starts in RUN.
- `validM=0` always produces a bubble and never stalls.

## Configuration
- `WB_INSTRET_EN` defined:
  - `instretW` increments by 1 on every edge where the captured `validW` is 1, misaligned loads included;
  - it wraps modulo 2^CNT_W.
- Not defined: `instretW` is tied to 0 and no counter flops are built.

## Structure
- Shared package `wb_pkg` holds:
  - the `resultsrc_e` enum (ALU, LOAD, PC4, IMM, CSR);
  - the load `funct3` constants (LB, LH, LW, LBU, LHU);
  - the `wb_state_e` enum (RUN, WAIT).
- Sub-module `load_extend`: combinational; takes `memrdata`, `off` and `funct3`; outputs the formatted word and the misaligned flag.

## Test plan
- **ALU passthrough:** `validM=1`, src=ALU, `aluresultM=0x1234`, `rdM=5`, `regwriteM=1` → next cycle `resultW=0x1234`, `rdW=5`, `regwriteW=1`, `stallM` never high.
- **Signed byte load:**
  - LB, `off=3`, `memrdata=0x80FF_0000`, `memrvalid=1` → `resultW=0xFFFF_FF80`.
  - Same with LBU → `resultW=0x0000_0080`.
- **Late response:** LW with `memrvalid` low for 3 cycles, then high with `0xDEADBEEF` → `stallM` high for 3 cycles; `validW=0` during them; then `resultW=0xDEADBEEF` with `validW=1`.
- **Misaligned and x0:**
  - LH at `off=1` → `misalignW=1`, `regwriteW=0`, `validW=1`.
  - ALU op to `rd=0` → `regwriteW=0`.
- **Reset mid-stall:** `rst` asserted during the second WAIT cycle → `stallM=0` immediately; all outputs 0 next cycle; a new ALU op then passes with latency 1.
- **Retirement count (`WB_INSTRET_EN`):** 10 valid instructions interleaved with 4 bubbles and 1 stalled load → `instretW=11`.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the MEM/WB writeback stage.
//   resultsrc_e : writeback result source select (3 bits, 101-111 treated as ALU)
//   F3Lb..F3Lhu : load funct3 encodings (size and signedness)
//   wb_state_e  : writeback FSM states (run / wait for data-memory response)
package wb_pkg;

    typedef enum logic [2:0] {
        SrcAlu  = 3'b000,
        SrcLoad = 3'b001,
        SrcPc4  = 3'b010,
        SrcImm  = 3'b011,
        SrcCsr  = 3'b100
    } resultsrc_e;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    typedef enum logic {
        StRun  = 1'b0,
        StWait = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load-data formatter.
// Ports:
//   memrdata   in  32 : raw aligned word from data memory
//   off        in  2  : byte offset within the word (address[1:0])
//   funct3     in  3  : load size / signedness
//   ldata      out 32 : byte/half/word selected and sign- or zero-extended
//   misaligned out 1  : halfword at odd offset, or word at non-zero offset
module load_extend
    import wb_pkg::*;
(
    input  logic [31:0] memrdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ldata,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = memrdata[{off, 3'b000} +: 8];
    assign w_half = memrdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        ldata      = memrdata;
        misaligned = 1'b0;
        case (funct3)
            F3Lb:  ldata = {{24{w_byte[7]}}, w_byte};
            F3Lbu: ldata = {24'h000000, w_byte};
            F3Lh: begin
                ldata      = {{16{w_half[15]}}, w_half};
                misaligned = off[0];
            end
            F3Lhu: begin
                ldata      = {16'h0000, w_half};
                misaligned = off[0];
            end
            // LW and every unused encoding load the full word.
            default: begin
                ldata      = memrdata;
                misaligned = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: registered MEM/WB stage for the RV32I core.
// Selects among ALU / load / PC+4 / immediate / CSR results, formats load data,
// flags misaligned loads and stalls upstream while a load response is outstanding.
// Optional feature macro: WB_INSTRET_EN (builds the retired-instruction counter).
// Ports:
//   clk, rst (sync, active-high)
//   validM, resultsrcM, funct3M, aluresultM, pcplus4M, immextM, csrdataM,
//   rdM, regwriteM                         : MEM-stage instruction
//   memrdata, memrvalid                    : data-memory response
//   stallM                                 : combinational upstream hold
//   resultW, rdW, regwriteW, validW,
//   misalignW, instretW                    : registered writeback outputs
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validM,
    input  logic [2:0]       resultsrcM,
    input  logic [2:0]       funct3M,
    input  logic [W-1:0]     aluresultM,
    input  logic [W-1:0]     pcplus4M,
    input  logic [W-1:0]     immextM,
    input  logic [W-1:0]     csrdataM,
    input  logic [RA_W-1:0]  rdM,
    input  logic             regwriteM,
    input  logic [W-1:0]     memrdata,
    input  logic             memrvalid,
    output logic             stallM,
    output logic [W-1:0]     resultW,
    output logic [RA_W-1:0]  rdW,
    output logic             regwriteW,
    output logic             validW,
    output logic             misalignW,
    output logic [CNT_W-1:0] instretW
);

    wb_state_e       r_state;
    logic [W-1:0]    r_result;
    logic [RA_W-1:0] r_rd;
    logic            r_regwrite;
    logic            r_valid;
    logic            r_misalign;

    logic            w_isload;
    logic            w_pending;
    logic            w_stall;
    logic [W-1:0]    w_ldata;
    logic            w_ld_misaligned;
    logic            w_misaligned;
    logic [W-1:0]    w_result;

    load_extend u_load_extend (
        .memrdata   (memrdata),
        .off        (aluresultM[1:0]),
        .funct3     (funct3M),
        .ldata      (w_ldata),
        .misaligned (w_ld_misaligned)
    );

    assign w_isload     = (resultsrcM == SrcLoad);
    assign w_pending    = validM & w_isload & ~memrvalid;
    // Misalignment only matters for real loads; funct3 is don't-care otherwise.
    assign w_misaligned = w_isload & w_ld_misaligned;

    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            if (r_state == StRun) begin
                w_stall = w_pending;
            end else begin
                w_stall = ~memrvalid;
            end
        end
    end

    always_comb begin
        w_result = aluresultM;
        case (resultsrcM)
            SrcLoad: w_result = w_ldata;
            SrcPc4:  w_result = pcplus4M;
            SrcImm:  w_result = immextM;
            SrcCsr:  w_result = csrdataM;
            default: w_result = aluresultM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_result   <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                StRun:   if (w_pending) r_state <= StWait;
                StWait:  if (memrvalid) r_state <= StRun;
                default: r_state <= StRun;
            endcase

            if (w_stall) begin
                // Bubble into WB; result and rd hold their last values.
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_misalign <= 1'b0;
            end else begin
                r_valid    <= validM;
                r_rd       <= rdM;
                r_result   <= w_result;
                r_misalign <= validM & w_misaligned;
                r_regwrite <= validM & regwriteM & (rdM != '0) & ~w_misaligned;
            end
        end
    end

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (!w_stall && validM) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instretW = r_instret;
`else
    assign instretW = '0;
`endif

    assign stallM    = w_stall;
    assign resultW   = r_result;
    assign rdW       = r_rd;
    assign regwriteW = r_regwrite;
    assign validW    = r_valid;
    assign misalignW = r_misalign;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    localparam int W     = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             validM;
    logic [2:0]       resultsrcM;
    logic [2:0]       funct3M;
    logic [W-1:0]     aluresultM;
    logic [W-1:0]     pcplus4M;
    logic [W-1:0]     immextM;
    logic [W-1:0]     csrdataM;
    logic [RA_W-1:0]  rdM;
    logic             regwriteM;
    logic [W-1:0]     memrdata;
    logic             memrvalid;
    logic             stallM;
    logic [W-1:0]     resultW;
    logic [RA_W-1:0]  rdW;
    logic             regwriteW;
    logic             validW;
    logic             misalignW;
    logic [CNT_W-1:0] instretW;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    writeback_stage #(
        .W     (W),
        .RA_W  (RA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .validM     (validM),
        .resultsrcM (resultsrcM),
        .funct3M    (funct3M),
        .aluresultM (aluresultM),
        .pcplus4M   (pcplus4M),
        .immextM    (immextM),
        .csrdataM   (csrdataM),
        .rdM        (rdM),
        .regwriteM  (regwriteM),
        .memrdata   (memrdata),
        .memrvalid  (memrvalid),
        .stallM     (stallM),
        .resultW    (resultW),
        .rdW        (rdW),
        .regwriteW  (regwriteW),
        .validW     (validW),
        .misalignW  (misalignW),
        .instretW   (instretW)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every retiring instruction must match the next queued expectation.
    always @(posedge clk) begin
        #1;
        if (!rst && validW === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: got retire rd=%0d res=%h, want no retire",
                         rdW, resultW);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rdW !== e.rd || regwriteW !== e.rw || misalignW !== e.mis ||
                    (e.chk && resultW !== e.res)) begin
                    errors++;
                    $display("FAIL retire: got res=%h rd=%0d rw=%b mis=%b, want res=%h rd=%0d rw=%b mis=%b",
                             resultW, rdW, regwriteW, misalignW, e.res, e.rd, e.rw, e.mis);
                end
            end
        end
    end

    task automatic set_m(input logic v, input logic [2:0] src, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                         input logic [31:0] mdata, input logic mvalid);
        validM     = v;
        resultsrcM = src;
        funct3M    = f3;
        aluresultM = alu;
        rdM        = rd;
        regwriteM  = rw;
        memrdata   = mdata;
        memrvalid  = mvalid;
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                        input logic mis, input logic chk);
        exp_t e;
        e.res = res;
        e.rd  = rd;
        e.rw  = rw;
        e.mis = mis;
        e.chk = chk;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [31:0] s;
        s = d >> (8 * off);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        pcplus4M = 32'h1000_0004;
        immextM  = 32'hFFFF_F800;
        csrdataM = 32'h0000_0300;
        set_m(1'b1, 3'b001, 3'b010, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0);
        #1;
        checks++;
        if (stallM !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got stallM=%b, want 0", stallM);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (resultW !== 32'h0 || rdW !== 5'd0 || regwriteW !== 1'b0 || validW !== 1'b0 ||
            misalignW !== 1'b0 || instretW !== 64'd0) begin
            errors++;
            $display("FAIL reset_values: got res=%h rd=%0d rw=%b v=%b mis=%b cnt=%0d, want all 0",
                     resultW, rdW, regwriteW, validW, misalignW, instretW);
        end
        @(negedge clk);
        rst = 1'b0;
        set_m(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_sources();
        logic [2:0]  srcs[6];
        logic [31:0] exp_v;
        srcs = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            // Odd ALU value with funct3=LH: misalignment must not apply to non-loads.
            set_m(1'b1, srcs[i], 3'b001, 32'h0000_1234 + i, 5'(5 + i), 1'b1, 32'h0, 1'b0);
            case (srcs[i])
                3'b010:  exp_v = 32'h1000_0004;
                3'b011:  exp_v = 32'hFFFF_F800;
                3'b100:  exp_v = 32'h0000_0300;
                default: exp_v = 32'h0000_1234 + i;
            endcase
            push(exp_v, 5'(5 + i), 1'b1, 1'b0, 1'b1);
            #1;
            checks++;
            if (stallM !== 1'b0) begin
                errors++;
                $display("FAIL src_stall[%0d]: got stallM=%b, want 0", i, stallM);
            end
            @(posedge clk);
            #2;
            checks++;
            if (validW !== 1'b1) begin
                errors++;
                $display("FAIL src_latency[%0d]: got validW=%b, want 1", i, validW);
            end
        end
        @(negedge clk);
        set_m(1'b0, 3'b001, 3'b000, 32'h0, 5'd4, 1'b1, 32'h0, 1'b1);
        #1;
        checks++;
        if (stallM !== 1'b0) begin
            errors++;
            $display("FAIL bubble_stall: got stallM=%b, want 0", stallM);
        end
        @(posedge clk);
        #2;
        checks++;
        if (validW !== 1'b0 || regwriteW !== 1'b0) begin
            errors++;
            $display("FAIL bubble: got validW=%b regwriteW=%b, want 0 0", validW, regwriteW);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s[8];
        logic [1:0]  offs[8];
        logic [31:0] datas[8];
        logic [31:0] exps[8];
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] d;
        logic [2:0]  rf3[5];
        f3s   = '{3'b000, 3'b100, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
        offs  = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
        datas = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                  32'h80FF_0000, 32'h80FF_0000, 32'h1234_8765, 32'hCAFE_F00D};
        exps  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0000_0000,
                  32'hFFFF_80FF, 32'h0000_80FF, 32'hFFFF_8765, 32'hCAFE_F00D};
        rf3   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                f3 = f3s[i];
                off = offs[i];
                d = datas[i];
            end else begin
                f3 = rf3[$urandom_range(0, 4)];
                d = $urandom;
                off = 2'($urandom_range(0, 3));
                if (f3 == 3'b001 || f3 == 3'b101) off[0] = 1'b0;
                if (f3 == 3'b010) off = 2'd0;
            end
            @(negedge clk);
            set_m(1'b1, 3'b001, f3, {30'h0000_0400, off}, 5'(10 + i), 1'b1, d, 1'b1);
            push((i < 8) ? exps[i] : model_load(f3, off, d), 5'(10 + i), 1'b1, 1'b0, 1'b1);
            #1;
            checks++;
            if (stallM !== 1'b0) begin
                errors++;
                $display("FAIL load_nostall[%0d]: got stallM=%b, want 0", i, stallM);
            end
            @(posedge clk);
            #2;
            checks++;
            if (validW !== 1'b1) begin
                errors++;
                $display("FAIL load_latency[%0d]: got validW=%b, want 1", i, validW);
            end
        end
        @(negedge clk);
        set_m(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_late_response();
        logic [31:0] prev_res;
        logic [4:0]  prev_rd;
        @(negedge clk);
        prev_res = resultW;
        prev_rd  = rdW;
        set_m(1'b1, 3'b001, 3'b010, 32'h0000_2000, 5'd12, 1'b1, 32'h1111_1111, 1'b0);
        push(32'hDEAD_BEEF, 5'd12, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stallM !== 1'b1) begin
                errors++;
                $display("FAIL late_stall[%0d]: got stallM=%b, want 1", i, stallM);
            end
            @(posedge clk);
            #2;
            checks++;
            if (validW !== 1'b0 || regwriteW !== 1'b0 || resultW !== prev_res ||
                rdW !== prev_rd) begin
                errors++;
                $display("FAIL late_bubble[%0d]: got v=%b rw=%b res=%h rd=%0d, want 0 0 %h %0d",
                         i, validW, regwriteW, resultW, rdW, prev_res, prev_rd);
            end
            @(negedge clk);
        end
        memrdata  = 32'hDEAD_BEEF;
        memrvalid = 1'b1;
        #1;
        checks++;
        if (stallM !== 1'b0) begin
            errors++;
            $display("FAIL late_release: got stallM=%b, want 0", stallM);
        end
        @(posedge clk);
        #2;
        checks++;
        if (validW !== 1'b1 || resultW !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL late_retire: got v=%b res=%h, want 1 deadbeef", validW, resultW);
        end
        @(negedge clk);
        set_m(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_misalign_x0();
        @(negedge clk);
        set_m(1'b1, 3'b001, 3'b001, 32'h0000_3001, 5'd13, 1'b1, 32'h1234_5678, 1'b1);
        push(32'h0, 5'd13, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (misalignW !== 1'b1 || regwriteW !== 1'b0 || validW !== 1'b1) begin
            errors++;
            $display("FAIL misalign_lh: got mis=%b rw=%b v=%b, want 1 0 1",
                     misalignW, regwriteW, validW);
        end
        @(negedge clk);
        set_m(1'b1, 3'b001, 3'b010, 32'h0000_3002, 5'd14, 1'b1, 32'h1234_5678, 1'b1);
        push(32'h0, 5'd14, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        set_m(1'b1, 3'b000, 3'b000, 32'h0000_0077, 5'd0, 1'b1, 32'h0, 1'b0);
        push(32'h0000_0077, 5'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        checks++;
        if (regwriteW !== 1'b0 || validW !== 1'b1 || misalignW !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: got rw=%b v=%b mis=%b, want 0 1 0",
                     regwriteW, validW, misalignW);
        end
        @(negedge clk);
        set_m(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        set_m(1'b1, 3'b001, 3'b010, 32'h0000_4000, 5'd20, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (stallM !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall: got stallM=%b, want 0", stallM);
        end
        @(posedge clk);
        #2;
        checks++;
        if (resultW !== 32'h0 || rdW !== 5'd0 || regwriteW !== 1'b0 || validW !== 1'b0 ||
            misalignW !== 1'b0 || instretW !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_values: got res=%h rd=%0d rw=%b v=%b mis=%b cnt=%0d, want all 0",
                     resultW, rdW, regwriteW, validW, misalignW, instretW);
        end
        @(negedge clk);
        rst = 1'b0;
        set_m(1'b1, 3'b000, 3'b000, 32'h0000_0055, 5'd9, 1'b1, 32'h0, 1'b0);
        push(32'h0000_0055, 5'd9, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (stallM !== 1'b0) begin
            errors++;
            $display("FAIL rst_then_run: got stallM=%b, want 0", stallM);
        end
        @(posedge clk);
        #2;
        checks++;
        if (validW !== 1'b1 || resultW !== 32'h0000_0055) begin
            errors++;
            $display("FAIL rst_then_alu: got v=%b res=%h, want 1 00000055", validW, resultW);
        end
        @(negedge clk);
        set_m(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_instret();
        logic [63:0] exp_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_m(1'b1, 3'b000, 3'b000, 32'h100 + i, 5'(1 + i), 1'b1, 32'h0, 1'b0);
            push(32'h100 + i, 5'(1 + i), 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            if (i == 1 || i == 3 || i == 5 || i == 7) begin
                set_m(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
                @(negedge clk);
            end
        end
        set_m(1'b1, 3'b001, 3'b010, 32'h0000_5000, 5'd30, 1'b1, 32'h0, 1'b0);
        push(32'h0BAD_F00D, 5'd30, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        memrdata  = 32'h0BAD_F00D;
        memrvalid = 1'b1;
        @(negedge clk);
        set_m(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
`ifdef WB_INSTRET_EN
        exp_cnt = 64'd11;
`else
        exp_cnt = 64'd0;
`endif
        checks++;
        if (instretW !== exp_cnt) begin
            errors++;
            $display("FAIL instret: got %0d, want %0d", instretW, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_sources();
        test_loads();
        test_late_response();
        test_misalign_x0();
        test_reset_mid_stall();
        test_instret();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
